// File: rtl/i_cache_2way.sv
// Two-way set-associative instruction cache with single-cycle lookup and a
// registered miss FSM that installs refill lines into an LRU-selected victim way.
module i_cache_2way #(
  parameter int unsigned INDEX_W  = 4,
  parameter int unsigned TAG_W    = 6,
  parameter int unsigned LINE_W   = 256,
  parameter int unsigned OFFSET_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ren,
  input  logic [INDEX_W-1:0]  index,
  input  logic [TAG_W-1:0]    tag,
  input  logic                ic_exp,
  input  logic                flush,
  input  logic [LINE_W-1:0]   ic_fill_data,
  input  logic                ic_miss_ack,
  output logic [LINE_W-1:0]   r_data,
  output logic                ic_hit,
  output logic                ic_miss,
  output logic [31:0]         ic_miss_addr
);

  localparam int unsigned SETS = 1 << INDEX_W;

  typedef enum logic [0:0] {StIdle, StMiss} state_e;

  state_e               r_state;
  state_e               w_state_next;
  logic [1:0][SETS-1:0] r_valid;
  logic [SETS-1:0]      r_lru;
  logic [TAG_W-1:0]     r_tag  [2][SETS];
  logic [LINE_W-1:0]    r_line [2][SETS];
  logic [INDEX_W-1:0]   r_miss_idx;
  logic [TAG_W-1:0]     r_miss_tag;
  logic                 r_miss_way;

  logic w_idle, w_hit0, w_hit1, w_req, w_req_hit, w_req_miss, w_fill, w_victim;

  assign w_idle     = (r_state == StIdle);
  assign w_hit0     = r_valid[0][index] & (r_tag[0][index] == tag);
  assign w_hit1     = r_valid[1][index] & (r_tag[1][index] == tag);
  assign w_req      = w_idle & ren & ~ic_exp;
  assign w_req_hit  = w_req & (w_hit0 | w_hit1);
  assign w_req_miss = w_req & ~(w_hit0 | w_hit1);
  assign w_fill     = (r_state == StMiss) & ic_miss_ack;
  // Prefer an empty way before evicting the LRU one
  assign w_victim   = ~r_valid[0][index] ? 1'b0 :
                      ~r_valid[1][index] ? 1'b1 : r_lru[index];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (w_req_miss) w_state_next = StMiss;
      StMiss: if (ic_miss_ack || ic_exp) w_state_next = StIdle;
    endcase
  end

  always_comb begin
    ic_hit  = w_req_hit;
    ic_miss = w_idle ? w_req_miss : 1'b1;
    r_data  = '0;
    if (w_req_hit) r_data = w_hit0 ? r_line[0][index] : r_line[1][index];
    if (w_idle) ic_miss_addr = 32'({tag, index}) << OFFSET_W;
    else        ic_miss_addr = 32'({r_miss_tag, r_miss_idx}) << OFFSET_W;
  end

  // Flush clears first; a coincident fill still leaves its line valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= '0;
      r_lru      <= '0;
      r_miss_idx <= '0;
      r_miss_tag <= '0;
      r_miss_way <= 1'b0;
    end else begin
      if (w_req_miss) begin
        r_miss_idx <= index;
        r_miss_tag <= tag;
        r_miss_way <= w_victim;
      end
      if (w_req_hit) r_lru[index] <= w_hit0;
      if (flush) begin
        r_valid <= '0;
        r_lru   <= '0;
      end
      if (w_fill) begin
        r_valid[r_miss_way][r_miss_idx] <= 1'b1;
        r_lru[r_miss_idx]               <= ~r_miss_way;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[r_miss_way][r_miss_idx]  <= r_miss_tag;
      r_line[r_miss_way][r_miss_idx] <= ic_fill_data;
    end
  end

endmodule

// File: tb/tb_i_cache_2way.sv
// Self-checking bench for i_cache_2way: directed scenarios plus randomized
// traffic compared against a behavioural cache model.
module tb_i_cache_2way;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ren, ic_exp, flush, ic_miss_ack;
  logic [3:0]   index;
  logic [5:0]   tag;
  logic [255:0] ic_fill_data;
  logic [255:0] r_data;
  logic         ic_hit, ic_miss;
  logic [31:0]  ic_miss_addr;

  int n_vec  = 0;
  int n_fail = 0;

  i_cache_2way dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ren          (ren),
    .index        (index),
    .tag          (tag),
    .ic_exp       (ic_exp),
    .flush        (flush),
    .ic_fill_data (ic_fill_data),
    .ic_miss_ack  (ic_miss_ack),
    .r_data       (r_data),
    .ic_hit       (ic_hit),
    .ic_miss      (ic_miss),
    .ic_miss_addr (ic_miss_addr)
  );

  always #5 clk = ~clk;

  // Behavioural model: resident lines per set/way, eviction order, one pending miss
  bit           m_valid [2][16];
  logic [5:0]   m_tag   [2][16];
  logic [255:0] m_data  [2][16];
  bit           m_lru   [16];
  bit           m_pend;
  int           m_idx, m_tag_l, m_way;
  logic         e_hit, e_miss;
  logic [255:0] e_data;
  logic [31:0]  e_addr;

  function automatic int m_lookup(input int idx, input logic [5:0] t);
    if (m_valid[0][idx] && m_tag[0][idx] == t) return 0;
    if (m_valid[1][idx] && m_tag[1][idx] == t) return 1;
    return -1;
  endfunction

  task automatic m_reset();
    for (int s = 0; s < 16; s++) begin
      m_valid[0][s] = 0;
      m_valid[1][s] = 0;
      m_lru[s]      = 0;
    end
    m_pend = 0;
  endtask

  task automatic model_eval();
    int w;
    e_hit  = 0;
    e_miss = 0;
    e_data = '0;
    if (!m_pend) begin
      e_addr = (32'(tag) << 9) | (32'(index) << 5);
      if (ren && !ic_exp) begin
        w = m_lookup(int'(index), tag);
        if (w >= 0) begin
          e_hit  = 1;
          e_data = m_data[w][index];
        end else begin
          e_miss = 1;
        end
      end
    end else begin
      e_miss = 1;
      e_addr = (32'(m_tag_l) << 9) | (32'(m_idx) << 5);
    end
  endtask

  task automatic model_step();
    int w;
    bit do_fill = 0;
    if (!m_pend) begin
      if (ren && !ic_exp) begin
        w = m_lookup(int'(index), tag);
        if (w >= 0) begin
          m_lru[index] = (w == 0);
        end else begin
          m_pend  = 1;
          m_idx   = int'(index);
          m_tag_l = int'(tag);
          if (!m_valid[0][index])      m_way = 0;
          else if (!m_valid[1][index]) m_way = 1;
          else                         m_way = int'(m_lru[index]);
        end
      end
    end else if (ic_miss_ack) begin
      do_fill = 1;
    end else if (ic_exp) begin
      m_pend = 0;
    end
    if (flush) begin
      for (int s = 0; s < 16; s++) begin
        m_valid[0][s] = 0;
        m_valid[1][s] = 0;
        m_lru[s]      = 0;
      end
    end
    if (do_fill) begin
      m_valid[m_way][m_idx] = 1;
      m_tag[m_way][m_idx]   = 6'(m_tag_l);
      m_data[m_way][m_idx]  = ic_fill_data;
      m_lru[m_idx]          = (m_way == 0);
      m_pend                = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input int idx, input int t);
    ren         = r;
    index       = 4'(idx);
    tag         = 6'(t);
    ic_exp      = 0;
    flush       = 0;
    ic_miss_ack = 0;
    #1;
  endtask

  task automatic fill_line(input int idx, input int t, input logic [255:0] d);
    drive(1, idx, t);
    tick();
    ic_miss_ack  = 1;
    ic_fill_data = d;
    #1;
    tick();
    ic_miss_ack = 0;
    ren         = 0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    drive(0, 0, 0);
    m_reset();
    #1;
    n_vec++; if (ic_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b want 0", ic_hit); end
    n_vec++; if (ic_miss !== 1'b0) begin n_fail++; $display("FAIL reset_miss: got %b want 0", ic_miss); end
    n_vec++; if (r_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", r_data); end
    #5;
    rst_n = 1;
    #1;
  endtask

  task automatic test_cold_miss();
    drive(1, 3, 'h2A);
    n_vec++; if (ic_miss !== 1'b1) begin n_fail++; $display("FAIL cold_miss: got %b want 1", ic_miss); end
    n_vec++; if (ic_hit !== 1'b0) begin n_fail++; $display("FAIL cold_hit: got %b want 0", ic_hit); end
    n_vec++; if (ic_miss_addr !== 32'h0000_5460) begin
      n_fail++; $display("FAIL cold_addr: got %h want 00005460", ic_miss_addr);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (ic_miss !== 1'b1) begin n_fail++; $display("FAIL hold_miss: got %b want 1", ic_miss); end
      n_vec++; if (ic_miss_addr !== 32'h0000_5460) begin
        n_fail++; $display("FAIL hold_addr: got %h want 00005460", ic_miss_addr);
      end
      tick();
    end
    ic_miss_ack  = 1;
    ic_fill_data = {32{8'hA5}};
    #1;
    n_vec++; if (ic_miss !== 1'b1) begin n_fail++; $display("FAIL ack_miss: got %b want 1", ic_miss); end
    n_vec++; if (ic_hit !== 1'b0) begin n_fail++; $display("FAIL ack_hit: got %b want 0", ic_hit); end
    n_vec++; if (r_data !== '0) begin n_fail++; $display("FAIL ack_data: got %h want 0", r_data); end
    tick();
    ic_miss_ack = 0;
    #1;
    n_vec++; if (ic_hit !== 1'b1) begin n_fail++; $display("FAIL post_fill_hit: got %b want 1", ic_hit); end
    n_vec++; if (r_data !== {32{8'hA5}}) begin
      n_fail++; $display("FAIL post_fill_data: got %h want a5..a5", r_data);
    end
    n_vec++; if (ic_miss !== 1'b0) begin n_fail++; $display("FAIL post_fill_miss: got %b want 0", ic_miss); end
    drive(0, 0, 0);
  endtask

  task automatic test_lru_evict();
    fill_line(5, 'h01, {32{8'h11}});
    fill_line(5, 'h02, {32{8'h22}});
    drive(1, 5, 'h01);
    n_vec++; if (r_data !== {32{8'h11}}) begin n_fail++; $display("FAIL lru_hit1: got %h", r_data); end
    tick();
    fill_line(5, 'h03, {32{8'h33}});
    drive(1, 5, 'h01);
    n_vec++; if (ic_hit !== 1'b1 || r_data !== {32{8'h11}}) begin
      n_fail++; $display("FAIL lru_keep01: hit %b data %h want 1 / 11..11", ic_hit, r_data);
    end
    drive(1, 5, 'h03);
    n_vec++; if (ic_hit !== 1'b1 || r_data !== {32{8'h33}}) begin
      n_fail++; $display("FAIL lru_new03: hit %b data %h want 1 / 33..33", ic_hit, r_data);
    end
    drive(1, 5, 'h02);
    n_vec++; if (ic_hit !== 1'b0 || ic_miss !== 1'b1) begin
      n_fail++; $display("FAIL lru_evict02: hit %b miss %b want 0/1", ic_hit, ic_miss);
    end
    drive(0, 0, 0);
  endtask

  task automatic test_abort();
    drive(1, 7, 'h10);
    tick();
    ic_exp = 1;
    #1;
    tick();
    drive(0, 7, 'h10);
    n_vec++; if (ic_miss !== 1'b0) begin n_fail++; $display("FAIL abort_miss: got %b want 0", ic_miss); end
    ic_miss_ack  = 1;
    ic_fill_data = {32{8'h77}};
    #1;
    tick();
    drive(1, 7, 'h10);
    n_vec++; if (ic_hit !== 1'b0 || ic_miss !== 1'b1) begin
      n_fail++; $display("FAIL abort_ignored_ack: hit %b miss %b want 0/1", ic_hit, ic_miss);
    end
    drive(0, 0, 0);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) fill_line(8 + i, 'h20 + i, {32{8'(8'h80 + i)}});
    for (int i = 0; i < 4; i++) begin
      drive(1, 8 + i, 'h20 + i);
      n_vec++; if (ic_hit !== 1'b1) begin n_fail++; $display("FAIL preflush_hit%0d: got %b want 1", i, ic_hit); end
    end
    drive(0, 0, 0);
    flush = 1;
    #1;
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 8 + i, 'h20 + i);
      n_vec++; if (ic_hit !== 1'b0) begin n_fail++; $display("FAIL flushed_hit%0d: got %b want 0", i, ic_hit); end
    end
    fill_line(9, 'h21, {32{8'h99}});
    drive(1, 8, 'h20);
    tick();
    ic_miss_ack  = 1;
    flush        = 1;
    ic_fill_data = {32{8'h88}};
    #1;
    tick();
    drive(1, 8, 'h20);
    n_vec++; if (ic_hit !== 1'b1 || r_data !== {32{8'h88}}) begin
      n_fail++; $display("FAIL flush_ack_fill: hit %b data %h want 1 / 88..88", ic_hit, r_data);
    end
    drive(1, 9, 'h21);
    n_vec++; if (ic_hit !== 1'b0) begin n_fail++; $display("FAIL flush_ack_other: got %b want 0", ic_hit); end
    drive(0, 0, 0);
  endtask

  task automatic test_reset_mid_miss();
    fill_line(12, 'h3F, {32{8'hCC}});
    drive(1, 13, 'h3E);
    tick();
    rst_n = 0;
    ren   = 0;
    #1;
    m_reset();
    n_vec++; if (ic_miss !== 1'b0) begin n_fail++; $display("FAIL rst_mid_miss: got %b want 0", ic_miss); end
    @(posedge clk);
    #1;
    rst_n = 1;
    #1;
    drive(1, 12, 'h3F);
    n_vec++; if (ic_hit !== 1'b0) begin n_fail++; $display("FAIL rst_line12: got %b want 0", ic_hit); end
    drive(1, 8, 'h20);
    n_vec++; if (ic_hit !== 1'b0) begin n_fail++; $display("FAIL rst_line8: got %b want 0", ic_hit); end
    drive(0, 0, 0);
  endtask

  task automatic test_exp_idle();
    fill_line(2, 'h05, {32{8'h55}});
    fill_line(2, 'h06, {32{8'h66}});
    drive(1, 2, 'h05);
    ic_exp = 1;
    #1;
    n_vec++; if (ic_hit !== 1'b0 || ic_miss !== 1'b0 || r_data !== '0) begin
      n_fail++; $display("FAIL exp_idle: hit %b miss %b data %h want 0/0/0", ic_hit, ic_miss, r_data);
    end
    tick();
    fill_line(2, 'h07, {32{8'h07}});
    drive(1, 2, 'h06);
    n_vec++; if (ic_hit !== 1'b1) begin n_fail++; $display("FAIL exp_lru_keep06: got %b want 1", ic_hit); end
    drive(1, 2, 'h05);
    n_vec++; if (ic_hit !== 1'b0) begin n_fail++; $display("FAIL exp_lru_evict05: got %b want 0", ic_hit); end
    drive(0, 0, 0);
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      ren    = ($urandom % 4) != 0;
      index  = 4'($urandom % 4);
      tag    = 6'('h30 + $urandom % 3);
      ic_exp = ($urandom % 10) == 0;
      flush  = ($urandom % 50) == 0;
      ic_miss_ack = m_pend ? (($urandom % 3) == 0) : (($urandom % 10) == 0);
      for (int k = 0; k < 8; k++) ic_fill_data[k*32 +: 32] = $urandom;
      #1;
      model_eval();
      n_vec++; if (ic_hit !== e_hit) begin n_fail++; $display("FAIL rnd_hit c%0d: got %b want %b", c, ic_hit, e_hit); end
      n_vec++; if (ic_miss !== e_miss) begin
        n_fail++; $display("FAIL rnd_miss c%0d: got %b want %b", c, ic_miss, e_miss);
      end
      n_vec++; if (r_data !== e_data) begin
        n_fail++; $display("FAIL rnd_data c%0d: got %h want %h", c, r_data, e_data);
      end
      n_vec++; if (ic_miss_addr !== e_addr) begin
        n_fail++; $display("FAIL rnd_addr c%0d: got %h want %h", c, ic_miss_addr, e_addr);
      end
      tick();
    end
    drive(0, 0, 0);
  endtask

  initial begin
    ic_fill_data = '0;
    test_reset();
    test_cold_miss();
    test_lru_evict();
    test_abort();
    test_flush();
    test_reset_mid_miss();
    test_exp_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
